// File: rtl/vif_rx_sink_if.sv
// Byte stream valid/data/ready handshake shared by the sender and vif_rx_sink.
interface my_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport AccessOut (input data, input valid, output ready);
    modport AccessIn  (output data, output valid, input ready);
endinterface

// File: rtl/vif_rx_sink.sv
// Handshake receiver: buffers accepted bytes in a small FIFO, re-presents them on a
// downstream valid/ready port, and tracks an XOR checksum and an accept counter.
module vif_rx_sink #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    my_if.AccessOut                    rx_if,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [7:0]                 out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic [1:0]                 state,
    output logic [7:0]                 rx_checksum,
    output logic [CNT_W-1:0]           rx_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } state_t;

    state_t           st;
    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [FW-1:0]    fill;
    logic [FW-1:0]    fill_nx;
    logic             out_valid_q;
    logic [7:0]       cs;
    logic [CNT_W-1:0] cnt;
    logic             push;
    logic             pop;

    assign rx_if.ready = !rst && !flush && (st != FULL);
    assign push        = rx_if.valid && rx_if.ready;
    assign pop         = out_valid_q && out_ready && !flush;
    assign fill_nx     = fill + FW'(push) - FW'(pop);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= rx_if.data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill        <= '0;
            st          <= EMPTY;
            out_valid_q <= 1'b0;
            cs          <= '0;
            cnt         <= '0;
        end else if (flush) begin
            // Flush discards buffered bytes and the checksum but keeps the lifetime count.
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill        <= '0;
            st          <= EMPTY;
            out_valid_q <= 1'b0;
            cs          <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                cs     <= cs ^ rx_if.data;
                cnt    <= cnt + CNT_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            fill        <= fill_nx;
            out_valid_q <= (fill_nx != '0);
            if (fill_nx == '0)
                st <= EMPTY;
            else if (fill_nx == FW'(DEPTH))
                st <= FULL;
            else
                st <= ACTIVE;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_valid_q ? mem[rd_ptr] : '0;
    assign fill_level  = fill;
    assign state       = st;
    assign rx_checksum = cs;
    assign rx_count    = cnt;

endmodule

// File: tb/tb_vif_rx_sink.sv
// Bench for vif_rx_sink: directed scenarios then random traffic, compared against a queue model.
module tb_vif_rx_sink;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        out_ready;
    logic        out_valid,  out_valid4;
    logic [7:0]  out_data,   out_data4;
    logic [2:0]  fill_level, fill_level4;
    logic [1:0]  state,      state4;
    logic [7:0]  rx_checksum, rx_checksum4;
    logic [15:0] rx_count;
    logic [3:0]  rx_count4;

    my_if bus ();
    my_if bus4 ();

    assign bus4.data  = bus.data;
    assign bus4.valid = bus.valid;

    vif_rx_sink #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .rx_if(bus), .flush(flush),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .fill_level(fill_level), .state(state),
        .rx_checksum(rx_checksum), .rx_count(rx_count)
    );

    // Narrow-counter copy on the same stimulus so counter wrap is reached quickly.
    vif_rx_sink #(.DEPTH(DEPTH), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .rx_if(bus4), .flush(flush),
        .out_valid(out_valid4), .out_data(out_data4), .out_ready(out_ready),
        .fill_level(fill_level4), .state(state4),
        .rx_checksum(rx_checksum4), .rx_count(rx_count4)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    byte unsigned q[$];
    byte unsigned m_cs  = 0;
    int unsigned  m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check ready, advance at the edge, update the model, check all outputs.
    task automatic tick();
        bit exp_ready, m_push, m_pop;
        byte unsigned d;
        int unsigned exp_state;
        #2;
        exp_ready = !rst && !flush && (q.size() != DEPTH);
        chk("ready", 32'(bus.ready), 32'(exp_ready));
        chk("ready4", 32'(bus4.ready), 32'(exp_ready));
        m_push = bus.valid && exp_ready;
        m_pop  = !rst && !flush && (q.size() > 0) && out_ready;
        d      = bus.data;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            m_cs  = 0;
            m_cnt = 0;
        end else if (flush) begin
            q.delete();
            m_cs = 0;
        end else begin
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
                q.push_back(d);
                m_cs  = m_cs ^ d;
                m_cnt = m_cnt + 1;
            end
        end
        exp_state = (q.size() == 0) ? 0 : (q.size() == DEPTH) ? 2 : 1;
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("out_data", 32'(out_data), (q.size() != 0) ? 32'(q[0]) : 32'h0);
        chk("fill_level", 32'(fill_level), 32'(q.size()));
        chk("state", 32'(state), 32'(exp_state));
        chk("rx_checksum", 32'(rx_checksum), 32'(m_cs));
        chk("rx_count", 32'(rx_count), m_cnt % 65536);
        chk("rx_count4", 32'(rx_count4), m_cnt % 16);
        chk("out_data4", 32'(out_data4), (q.size() != 0) ? 32'(q[0]) : 32'h0);
        chk("fill_level4", 32'(fill_level4), 32'(q.size()));
    endtask

    initial begin
        int unsigned cnt_before;
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        bus.valid = 1'b1;
        bus.data  = 8'h5A;
        @(posedge clk);
        #1;

        // Reset held with valid asserted
        tick();
        tick();
        rst = 1'b0;
        bus.valid = 1'b0;
        tick();

        // Single byte, held until taken
        bus.valid = 1'b1;
        bus.data  = 8'hA5;
        tick();
        bus.valid = 1'b0;
        bus.data  = 8'h00;
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Fill to FULL, fifth byte stalls then lands after a pop
        for (int i = 1; i <= 4; i++) begin
            bus.valid = 1'b1;
            bus.data  = 8'(8'h11 * i);
            tick();
        end
        bus.data = 8'h55;
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        bus.valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // Streaming at full rate
        bus.valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.data = 8'(i);
            tick();
            chk("stream_fill", 32'(fill_level <= 1), 32'd1);
        end
        bus.valid = 1'b0;
        tick();

        // Flush with three entries buffered
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.valid = 1'b1;
            bus.data  = 8'(8'hC0 + i);
            tick();
        end
        cnt_before = m_cnt;
        flush     = 1'b1;
        out_ready = 1'b1;
        bus.data  = 8'hEE;
        tick();
        flush = 1'b0;
        bus.valid = 1'b0;
        chk("flush_count_kept", 32'(rx_count), 32'(cnt_before));
        tick();

        // Pointer wrap over 3*DEPTH pushes with no pops, drained in steps
        for (int i = 0; i < 3 * DEPTH; i++) begin
            out_ready = 1'b0;
            bus.valid = 1'b1;
            bus.data  = 8'($urandom);
            tick();
            if (i % DEPTH == DEPTH - 1) begin
                bus.valid = 1'b0;
                out_ready = 1'b1;
                for (int k = 0; k < DEPTH; k++) tick();
            end
        end

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            bus.valid = ($urandom_range(0, 3) != 0);
            bus.data  = 8'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            rst       = ($urandom_range(0, 150) == 0);
            tick();
        end
        rst   = 1'b0;
        flush = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
